// File: rtl/uart_tx_8n1_if.sv
// rtl/uart_tx_8n1_if.sv - byte request / serial status bundle between an ASCII sender and uart_tx_8n1
interface uart_tx_8n1_if;
    logic       start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (output start, tx_data, input tx, tx_busy, tx_done);
    modport slave  (input start, tx_data, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with internal baud divider; UART_TX_PARITY_EN adds an even-parity bit (8E1)
module uart_tx_8n1 #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_8n1_if.slave  bus
);
    localparam int              CNT_W    = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             bit_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_end = (cnt_q == CNT_LAST);

        // The divider free-runs within a frame and restarts at every bit boundary.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = START;
                    shift_d = bus.tx_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Serial UART transmitter sitting directly downstream of the ASCII sender stages (DHT, watch/stopwatch text senders).
- Consumes a one-cycle `start` pulse plus a byte, and shifts the byte out on the `tx` pin as an asynchronous 8N1 frame (LSB first).
- Reports `tx_busy` so the upstream sender can pace its next byte.
- Contains its own baud divider; no external tick is required.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- BIT_CYCLES, CLK_FREQ/BAUD (integer division, truncated), clock cycles per serial bit; must be ≥ 2; may be overridden directly for simulation.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to send `tx_data`.
- tx_data  input  8  byte to transmit; sampled only on an accepted start.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset:
  - Synchronous: applied on the clk edge where rst=1, including mid-frame.
  - After that edge: tx=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
  - A frame in flight is aborted, and the line returns high on that edge.
- Accept rule: `start` is accepted on edge N only when the state is IDLE and rst=0.
  - On acceptance, `tx_data` is latched into the shift register.
  - After edge N: tx_busy=1 and tx=0 (start bit).
  - The upstream sender sees tx_busy=1 on edge N+1; this is required by its "!tx_busy && !send" pacing.
- Start while busy (non-IDLE) is ignored. The frame in progress is unaffected, and the latched byte does not change.
- The registered output `tx` changes only on bit boundaries. Each bit is held exactly BIT_CYCLES clocks, timed by a baud counter running 0..BIT_CYCLES-1 and cleared on entry to each state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, tx_busy=0. Goes to START on an accepted start.
  - START: tx=0 for BIT_CYCLES. Then goes to DATA with bit index 0.
  - DATA: tx=shift[0]; the register shifts right at the end of each bit. After bit index 7 completes, goes to STOP.
  - STOP: tx=1 for BIT_CYCLES. Then goes to IDLE with tx_busy=0 and tx_done=1 for exactly one cycle.
- Frame length: tx_busy is high for exactly 10*BIT_CYCLES cycles (11*BIT_CYCLES with parity). tx_done coincides with the first cycle of tx_busy=0.
- Back-to-back: a start arriving in the first IDLE cycle (the same cycle tx_done=1) is accepted. tx then goes low on the next edge with no extra idle gap.
- Baud counter width: clog2(BIT_CYCLES). Bit index: 3 bits. No wrap beyond 7.
- tx_done and tx_busy are never both high.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 latched data bits) for BIT_CYCLES.
  - Frame becomes 8E1, 11 bits; tx_busy high for 11*BIT_CYCLES.
- Undefined: no PARITY state exists; the frame is 8N1, 10 bits.

Test Plan:
- BIT_CYCLES=10, rst held 3 cycles then released -> tx=1, tx_busy=0, tx_done=0 throughout; no toggling for 50 cycles.
- start pulse with tx_data=8'h54 ("T") -> tx_busy=1 the cycle after start.
  - tx line sampled at the mid-point of each bit reads 0,0,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
  - tx_busy high for exactly 100 cycles; tx_done is a single pulse at cycle 101.
- Start pulsed again at cycle 40 of a frame with tx_data=8'hFF -> ignored; the frame still carries 8'h54; the line stays idle after the stop bit.
- Start asserted in the tx_done cycle with 8'h0A ("\n") -> tx falls on the next edge; no idle bit between frames; second frame decodes 8'h0A.
- rst asserted at cycle 55 of a frame (mid data) -> tx=1 and tx_busy=0 after that edge; a new start afterwards sends 8'h41 correctly.
- With UART_TX_PARITY_EN, send 8'h07 -> parity bit=1, tx_busy high 110 cycles; send 8'h03 -> parity bit=0.
